// File: rtl/pll_lock_sequencer.sv
// Supervisory FSM for the ADPLL loop controller: holds the loop in reset, waits for
// frequency lock, checks that it settles, watches for loss of lock and retries a bounded number of times.
module pll_lock_sequencer #(
    parameter int unsigned RST_CYCLES    = 4,
    parameter int unsigned ACQ_TIMEOUT   = 64,
    parameter int unsigned SETTLE_CYCLES = 8,
    parameter int unsigned LOL_THRESH    = 4,
    parameter int unsigned MAX_RETRY     = 3
) (
    input  logic       phase_clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       freq_lock,
    input  logic       p_up,
    input  logic       p_down,
    input  logic [4:0] dco_code,
    output logic       ctrl_reset,
    output logic       pll_locked,
    output logic       lock_fail,
    output logic [2:0] retry_cnt,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_RESET_LOOP = 3'd1,
        ST_ACQUIRE    = 3'd2,
        ST_SETTLE     = 3'd3,
        ST_LOCKED     = 3'd4,
        ST_RETRY      = 3'd5,
        ST_FAIL       = 3'd6
    } state_e;

    typedef enum logic [1:0] {
        DIR_NONE = 2'd0,
        DIR_INC  = 2'd1,
        DIR_DEC  = 2'd2
    } dir_e;

    localparam logic [7:0] RST_LAST_C    = 8'(RST_CYCLES - 1);
    localparam logic [7:0] ACQ_LAST_C    = 8'(ACQ_TIMEOUT - 1);
    localparam logic [7:0] SETTLE_LAST_C = 8'(SETTLE_CYCLES - 1);
    localparam logic [7:0] LOL_THRESH_C  = 8'(LOL_THRESH);
    localparam logic [2:0] MAX_RETRY_C   = 3'(MAX_RETRY);

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] run_q, run_d, run_next_s;
    dir_e       dir_q, dir_d, dir_s;
    logic [2:0] retry_q, retry_d;
    logic       ctrl_reset_q, ctrl_reset_d;
    logic       pll_locked_q, pll_locked_d;
    logic       lock_fail_q, lock_fail_d;
    logic       rail_s;
    logic       lol_s;

    // State, counters and registered outputs
    always_ff @(posedge phase_clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 8'd0;
            run_q        <= 8'd0;
            dir_q        <= DIR_NONE;
            retry_q      <= 3'd0;
            ctrl_reset_q <= 1'b1;
            pll_locked_q <= 1'b0;
            lock_fail_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            run_q        <= run_d;
            dir_q        <= dir_d;
            retry_q      <= retry_d;
            ctrl_reset_q <= ctrl_reset_d;
            pll_locked_q <= pll_locked_d;
            lock_fail_q  <= lock_fail_d;
        end
    end

    // Phase-error run tracking; a run only grows while the detector keeps pushing one way
    always_comb begin
        dir_s      = DIR_NONE;
        run_next_s = 8'd0;
        if (p_down && !p_up) begin
            dir_s = DIR_INC;
        end else if (p_up && !p_down) begin
            dir_s = DIR_DEC;
        end else begin
            dir_s = DIR_NONE;
        end
        if (dir_s == DIR_NONE) begin
            run_next_s = 8'd0;
        end else if (dir_s == dir_q) begin
            run_next_s = (run_q == 8'hFF) ? 8'hFF : run_q + 8'd1;
        end else begin
            run_next_s = 8'd1;
        end
        rail_s = (dco_code == 5'd0) || (dco_code == 5'd31);
        lol_s  = (run_next_s >= LOL_THRESH_C) || !freq_lock || rail_s;
    end

    // Next-state logic; dropping enable parks the sequencer from anywhere
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        run_d   = run_q;
        dir_d   = dir_q;
        retry_d = retry_q;
        if (!enable) begin
            state_d = ST_IDLE;
            cnt_d   = 8'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_RESET_LOOP;
                    cnt_d   = 8'd0;
                    retry_d = 3'd0;
                end
                ST_RESET_LOOP: begin
                    if (cnt_q == RST_LAST_C) begin
                        state_d = ST_ACQUIRE;
                        cnt_d   = 8'd0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                ST_ACQUIRE: begin
                    if (freq_lock) begin
                        state_d = ST_SETTLE;
                        cnt_d   = 8'd0;
                    end else if (cnt_q == ACQ_LAST_C) begin
                        state_d = ST_RETRY;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                ST_SETTLE: begin
                    if (!freq_lock) begin
                        state_d = ST_RETRY;
                    end else if (cnt_q == SETTLE_LAST_C) begin
                        state_d = ST_LOCKED;
                        run_d   = 8'd0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                ST_LOCKED: begin
                    run_d = run_next_s;
                    dir_d = dir_s;
                    if (lol_s) begin
                        state_d = ST_RETRY;
                    end else begin
                        state_d = ST_LOCKED;
                    end
                end
                ST_RETRY: begin
                    if (retry_q == MAX_RETRY_C) begin
                        state_d = ST_FAIL;
                    end else begin
                        state_d = ST_RESET_LOOP;
                        retry_d = retry_q + 3'd1;
                        cnt_d   = 8'd0;
                    end
                end
                ST_FAIL: begin
                    state_d = ST_FAIL;
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = 8'd0;
                end
            endcase
        end
    end

    // Moore output decode of the upcoming state so the output flops line up with state_q
    always_comb begin
        ctrl_reset_d = 1'b0;
        pll_locked_d = 1'b0;
        lock_fail_d  = 1'b0;
        case (state_d)
            ST_IDLE, ST_RESET_LOOP: begin
                ctrl_reset_d = 1'b1;
            end
            ST_FAIL: begin
                ctrl_reset_d = 1'b1;
                lock_fail_d  = 1'b1;
            end
            ST_LOCKED: begin
                pll_locked_d = 1'b1;
            end
            default: begin
                ctrl_reset_d = 1'b0;
                pll_locked_d = 1'b0;
                lock_fail_d  = 1'b0;
            end
        endcase
    end

    assign ctrl_reset = ctrl_reset_q;
    assign pll_locked = pll_locked_q;
    assign lock_fail  = lock_fail_q;
    assign retry_cnt  = retry_q;
    assign state      = state_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench: stimulus pushes hand-computed expected outputs tagged with a target cycle;
// a negedge monitor pops and compares them against the DUT.
module tb_pll_lock_sequencer;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_RL     = 3'd1;
    localparam logic [2:0] S_ACQ    = 3'd2;
    localparam logic [2:0] S_SETTLE = 3'd3;
    localparam logic [2:0] S_LOCKED = 3'd4;
    localparam logic [2:0] S_RETRY  = 3'd5;
    localparam logic [2:0] S_FAIL   = 3'd6;

    logic       phase_clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       freq_lock;
    logic       p_up;
    logic       p_down;
    logic [4:0] dco_code;
    logic       ctrl_reset;
    logic       pll_locked;
    logic       lock_fail;
    logic [2:0] retry_cnt;
    logic [2:0] state;

    typedef struct {
        int unsigned at;
        logic [8:0]  vec;
        string       name;
    } exp_t;

    exp_t        sb_q[$];
    int unsigned cyc     = 0;
    int          n_checks = 0;
    int          n_fail   = 0;

    pll_lock_sequencer dut (
        .phase_clk (phase_clk),
        .reset     (reset),
        .enable    (enable),
        .freq_lock (freq_lock),
        .p_up      (p_up),
        .p_down    (p_down),
        .dco_code  (dco_code),
        .ctrl_reset(ctrl_reset),
        .pll_locked(pll_locked),
        .lock_fail (lock_fail),
        .retry_cnt (retry_cnt),
        .state     (state)
    );

    initial forever #5 phase_clk = ~phase_clk;

    always @(posedge phase_clk) cyc <= cyc + 1;

    // Expected outputs for a state: ctrl_reset in IDLE/RESET_LOOP/FAIL, locked only in LOCKED, fail only in FAIL
    function automatic logic [8:0] pack_exp(input logic [2:0] st, input logic [2:0] rc);
        logic cr, pl, lf;
        cr = (st == S_IDLE) || (st == S_RL) || (st == S_FAIL);
        pl = (st == S_LOCKED);
        lf = (st == S_FAIL);
        return {st, cr, pl, lf, rc};
    endfunction

    task automatic push_exp(input int unsigned d, input logic [2:0] st, input logic [2:0] rc,
                            input string nm);
        exp_t e;
        e.at   = cyc + d;
        e.vec  = pack_exp(st, rc);
        e.name = nm;
        sb_q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge phase_clk);
    endtask

    always @(negedge phase_clk) begin : monitor
        logic [8:0] act;
        exp_t       e;
        act = {state, ctrl_reset, pll_locked, lock_fail, retry_cnt};
        while (sb_q.size() > 0 && sb_q[0].at <= cyc) begin
            e = sb_q.pop_front();
            n_checks++;
            if (e.at < cyc) begin
                n_fail++;
                $display("FAIL %s: check for cycle %0d missed, now cycle %0d", e.name, e.at, cyc);
            end else if (act !== e.vec) begin
                n_fail++;
                $display("FAIL %s: got state=%0d ctrl_reset=%b pll_locked=%b lock_fail=%b retry_cnt=%0d, expected state=%0d ctrl_reset=%b pll_locked=%b lock_fail=%b retry_cnt=%0d",
                         e.name, act[8:6], act[5], act[4], act[3], act[2:0],
                         e.vec[8:6], e.vec[5], e.vec[4], e.vec[3], e.vec[2:0]);
            end
        end
    end

    initial begin
        reset = 1'b1; enable = 1'b0; freq_lock = 1'b0;
        p_up = 1'b0; p_down = 1'b0; dco_code = 5'd16;
        push_exp(1, S_IDLE, 3'd0, "reset_state");
        tick(1);

        // Plan 1: clean acquisition, freq_lock rises on the 10th ACQUIRE cycle
        reset = 1'b0; enable = 1'b1;
        push_exp(1,  S_RL,     3'd0, "t1_rl_first");
        push_exp(4,  S_RL,     3'd0, "t1_rl_last");
        push_exp(5,  S_ACQ,    3'd0, "t1_acq_entry");
        push_exp(14, S_ACQ,    3'd0, "t1_acq_10th");
        push_exp(15, S_SETTLE, 3'd0, "t1_settle_first");
        push_exp(22, S_SETTLE, 3'd0, "t1_settle_8th");
        push_exp(23, S_LOCKED, 3'd0, "t1_locked");
        tick(14);
        freq_lock = 1'b1;
        tick(9);

        // Plan 3: alternating INC/DEC holds lock, then four INC in a row drop it
        push_exp(50,  S_LOCKED, 3'd0, "t3_alt_mid");
        push_exp(100, S_LOCKED, 3'd0, "t3_alt_end");
        for (int i = 0; i < 100; i++) begin
            p_down = (i % 2 == 0) ? 1'b1 : 1'b0;
            p_up   = (i % 2 == 1) ? 1'b1 : 1'b0;
            tick(1);
        end
        p_down = 1'b1; p_up = 1'b0;
        push_exp(3,  S_LOCKED, 3'd0, "t3_run3_locked");
        push_exp(4,  S_RETRY,  3'd0, "t3_run4_retry");
        push_exp(5,  S_RL,     3'd1, "t3_reacquire");
        push_exp(18, S_LOCKED, 3'd1, "t3_relock");
        tick(4);
        p_down = 1'b0;
        tick(14);

        // Plan 4: one-cycle DCO rail at 31, then at 0
        dco_code = 5'd31;
        push_exp(1,  S_RETRY,  3'd1, "t4_rail31_retry");
        push_exp(2,  S_RL,     3'd2, "t4_rail31_count");
        push_exp(15, S_LOCKED, 3'd2, "t4_rail31_relock");
        tick(1);
        dco_code = 5'd16;
        tick(14);
        dco_code = 5'd0;
        push_exp(1,  S_RETRY,  3'd2, "t4_rail0_retry");
        push_exp(2,  S_RL,     3'd3, "t4_rail0_count");
        push_exp(15, S_LOCKED, 3'd3, "t4_rail0_relock");
        tick(1);
        dco_code = 5'd16;
        tick(14);

        // Plan 5: new session, freq_lock drops on 5th SETTLE cycle; then disable mid-SETTLE
        enable = 1'b0;
        push_exp(1, S_IDLE, 3'd3, "t5_disable_locked");
        tick(1);
        enable = 1'b1;
        push_exp(1,  S_RL,     3'd0, "t5_retry_cleared");
        push_exp(5,  S_ACQ,    3'd0, "t5_acq");
        push_exp(6,  S_SETTLE, 3'd0, "t5_settle_1st");
        push_exp(10, S_SETTLE, 3'd0, "t5_settle_5th");
        push_exp(11, S_RETRY,  3'd0, "t5_settle_drop");
        push_exp(12, S_RL,     3'd1, "t5_reacquire");
        tick(10);
        freq_lock = 1'b0;
        tick(1);
        freq_lock = 1'b1;
        push_exp(5, S_ACQ,    3'd1, "t5b_acq");
        push_exp(6, S_SETTLE, 3'd1, "t5b_settle_1st");
        push_exp(8, S_SETTLE, 3'd1, "t5b_settle_3rd");
        push_exp(9, S_IDLE,   3'd1, "t5b_disable_settle");
        tick(8);
        enable = 1'b0;
        tick(1);

        // Plan 2: freq_lock never asserts, four timeouts end in FAIL
        freq_lock = 1'b0; enable = 1'b1;
        push_exp(1,   S_RL,    3'd0, "t2_rl");
        push_exp(5,   S_ACQ,   3'd0, "t2_acq_first");
        push_exp(68,  S_ACQ,   3'd0, "t2_acq_64th");
        push_exp(69,  S_RETRY, 3'd0, "t2_timeout1");
        push_exp(70,  S_RL,    3'd1, "t2_retry1");
        push_exp(137, S_ACQ,   3'd1, "t2_acq2_last");
        push_exp(138, S_RETRY, 3'd1, "t2_timeout2");
        push_exp(139, S_RL,    3'd2, "t2_retry2");
        push_exp(208, S_RL,    3'd3, "t2_retry3");
        push_exp(276, S_RETRY, 3'd3, "t2_timeout4");
        push_exp(277, S_FAIL,  3'd3, "t2_fail");
        push_exp(280, S_FAIL,  3'd3, "t2_fail_hold");
        tick(280);
        enable = 1'b0;
        push_exp(1, S_IDLE, 3'd3, "t2_fail_exit");
        tick(1);

        // Plan 6: lock with one retry consumed, then async reset between edges
        enable = 1'b1; freq_lock = 1'b1;
        push_exp(1,  S_RL,     3'd0, "t6_rl");
        push_exp(14, S_LOCKED, 3'd0, "t6_locked");
        tick(14);
        dco_code = 5'd31;
        push_exp(1,  S_RETRY,  3'd0, "t6_rail_retry");
        push_exp(2,  S_RL,     3'd1, "t6_rail_count");
        push_exp(15, S_LOCKED, 3'd1, "t6_relock");
        tick(1);
        dco_code = 5'd16;
        tick(14);
        @(posedge phase_clk);
        #2;
        reset = 1'b1;
        push_exp(0, S_IDLE, 3'd0, "t6_async_reset");
        tick(1);
        push_exp(1, S_IDLE, 3'd0, "t6_reset_held");
        tick(1);
        reset = 1'b0; enable = 1'b0;
        tick(2);

        for (int i = 0; i < 20 && sb_q.size() > 0; i++) @(negedge phase_clk);
        while (sb_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: check for cycle %0d never evaluated, now cycle %0d",
                     sb_q[0].name, sb_q[0].at, cyc);
            void'(sb_q.pop_front());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
